// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: opcodes, control FSM states and datapath
// select encodings.
package cpu_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_TRAP
  } state_t;

  typedef enum logic [1:0] {PC_PLUS4 = 2'd0, PC_IMM = 2'd1, PC_ALU = 2'd2} pc_src_t;
  typedef enum logic [1:0] {A_RS1 = 2'd0, A_PC = 2'd1, A_ZERO = 2'd2} alu_a_t;
  typedef enum logic [1:0] {ALU_ADD = 2'd0, ALU_SUB = 2'd1, ALU_FUNCT = 2'd2} alu_op_t;
  typedef enum logic [1:0] {WB_ALU = 2'd0, WB_MEM = 2'd1, WB_PC4 = 2'd2, WB_IMM = 2'd3} wb_sel_t;

  function automatic logic opcode_valid(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
      OP_LOAD, OP_STORE, OP_OP, OP_IMM: return 1'b1;
      default:                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_fsm_if.sv
// Control bundle between the multi-cycle control FSM (master) and the
// shared datapath (slave).
interface control_fsm_if;
  logic [6:0]  opcode;
  logic        branch_taken;
  logic        mem_ready;
  logic        ir_en;
  logic        pc_en;
  logic [1:0]  pc_src;
  logic        mem_rd;
  logic        mem_wr;
  logic        mem_addr_sel;
  logic [1:0]  alu_a_sel;
  logic        alu_b_sel;
  logic [1:0]  alu_op;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        retire;
  logic [31:0] instret;
  logic        trap;

  modport master (
    input  opcode, branch_taken, mem_ready,
    output ir_en, pc_en, pc_src, mem_rd, mem_wr, mem_addr_sel,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, instret, trap
  );

  modport slave (
    output opcode, branch_taken, mem_ready,
    input  ir_en, pc_en, pc_src, mem_rd, mem_wr, mem_addr_sel,
           alu_a_sel, alu_b_sel, alu_op, rf_we, wb_sel, retire, instret, trap
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control unit: FETCH/DECODE/EXECUTE/MEM/WB sequencing,
// illegal-opcode trap and retired-instruction counter.
module control_fsm
  import cpu_pkg::*;
(
  input  logic          clk,
  input  logic          reset,
  control_fsm_if.master bus
);

  state_t      r_state, w_next;
  logic [31:0] r_instret;

  logic    w_ir_en, w_pc_en, w_mem_rd, w_mem_wr, w_mem_addr_sel;
  logic    w_alu_b_sel, w_rf_we, w_retire, w_trap;
  pc_src_t w_pc_src;
  alu_a_t  w_alu_a_sel;
  alu_op_t w_alu_op;
  wb_sel_t w_wb_sel;

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_FETCH;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next         = r_state;
    w_ir_en        = 1'b0;
    w_pc_en        = 1'b0;
    w_pc_src       = PC_PLUS4;
    w_mem_rd       = 1'b0;
    w_mem_wr       = 1'b0;
    w_mem_addr_sel = 1'b0;
    w_alu_a_sel    = A_RS1;
    w_alu_b_sel    = 1'b0;
    w_alu_op       = ALU_ADD;
    w_rf_we        = 1'b0;
    w_wb_sel       = WB_ALU;
    w_retire       = 1'b0;
    w_trap         = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_mem_rd = 1'b1;
        if (bus.mem_ready) begin
          w_ir_en = 1'b1;
          w_next  = S_DECODE;
        end
      end
      S_DECODE: w_next = opcode_valid(bus.opcode) ? S_EXECUTE : S_TRAP;
      S_EXECUTE: begin
        w_next = S_WB;
        case (bus.opcode)
          OP_OP:  w_alu_op = ALU_FUNCT;
          OP_IMM: begin
            w_alu_b_sel = 1'b1;
            w_alu_op    = ALU_FUNCT;
          end
          OP_LOAD, OP_STORE: begin
            w_alu_b_sel = 1'b1;
            w_next      = S_MEM;
          end
          OP_JALR: w_alu_b_sel = 1'b1;
          OP_AUIPC: begin
            w_alu_a_sel = A_PC;
            w_alu_b_sel = 1'b1;
          end
          OP_BRANCH: begin
            w_alu_op = ALU_SUB;
            w_pc_en  = 1'b1;
            w_pc_src = bus.branch_taken ? PC_IMM : PC_PLUS4;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end
          default: ;
        endcase
      end
      S_MEM: begin
        w_mem_addr_sel = 1'b1;
        w_mem_rd       = (bus.opcode == OP_LOAD);
        w_mem_wr       = (bus.opcode == OP_STORE);
        if (bus.mem_ready) begin
          if (bus.opcode == OP_STORE) begin
            w_pc_en  = 1'b1;
            w_retire = 1'b1;
            w_next   = S_FETCH;
          end else begin
            w_next   = S_WB;
          end
        end
      end
      S_WB: begin
        w_rf_we  = 1'b1;
        w_pc_en  = 1'b1;
        w_retire = 1'b1;
        w_next   = S_FETCH;
        case (bus.opcode)
          OP_LOAD: w_wb_sel = WB_MEM;
          OP_JAL: begin
            w_wb_sel = WB_PC4;
            w_pc_src = PC_IMM;
          end
          OP_JALR: begin
            w_wb_sel = WB_PC4;
            w_pc_src = PC_ALU;
          end
          OP_LUI:  w_wb_sel = WB_IMM;
          default: w_wb_sel = WB_ALU;
        endcase
      end
      S_TRAP: w_trap = 1'b1;
      default: w_next = S_FETCH;
    endcase

    // Reset silences the bus even mid-transaction so memory never sees a stray strobe.
    if (reset) begin
      w_ir_en        = 1'b0;
      w_pc_en        = 1'b0;
      w_mem_rd       = 1'b0;
      w_mem_wr       = 1'b0;
      w_mem_addr_sel = 1'b0;
      w_rf_we        = 1'b0;
      w_retire       = 1'b0;
      w_trap         = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)         r_instret <= 32'd0;
    else if (w_retire) r_instret <= r_instret + 32'd1;
  end

  assign bus.ir_en        = w_ir_en;
  assign bus.pc_en        = w_pc_en;
  assign bus.pc_src       = w_pc_src;
  assign bus.mem_rd       = w_mem_rd;
  assign bus.mem_wr       = w_mem_wr;
  assign bus.mem_addr_sel = w_mem_addr_sel;
  assign bus.alu_a_sel    = w_alu_a_sel;
  assign bus.alu_b_sel    = w_alu_b_sel;
  assign bus.alu_op       = w_alu_op;
  assign bus.rf_we        = w_rf_we;
  assign bus.wb_sel       = w_wb_sel;
  assign bus.retire       = w_retire;
  assign bus.instret      = r_instret;
  assign bus.trap         = w_trap;

endmodule

// File: tb/tb_control_fsm.sv
// Directed bench for control_fsm: walks each instruction class cycle by cycle
// and compares strobes/selects against hand-computed values.
module tb_control_fsm;
  import cpu_pkg::*;

  logic clk;
  logic reset;
  control_fsm_if bus();

  control_fsm dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  // {ir_en, pc_en, mem_rd, mem_wr, rf_we, retire, trap}
  function automatic logic [6:0] strb();
    return {bus.ir_en, bus.pc_en, bus.mem_rd, bus.mem_wr, bus.rf_we, bus.retire, bus.trap};
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic fe_de(input logic [6:0] op, input string tag);
    bus.opcode = op;
    chk({tag, "_fetch"}, {25'd0, strb()}, 32'b1010000);
    chk({tag, "_fetch_addr"}, {31'd0, bus.mem_addr_sel}, 32'd0);
    cyc();
    chk({tag, "_decode"}, {25'd0, strb()}, 32'b0000000);
    cyc();
  endtask

  initial begin
    reset = 1'b1;
    bus.opcode = OP_IMM;
    bus.branch_taken = 1'b0;
    bus.mem_ready = 1'b1;
    #1;
    chk("rst_strb", {25'd0, strb()}, 32'd0);
    cyc();
    chk("rst_instret", bus.instret, 32'd0);
    reset = 1'b0;
    #1;

    // ADDI
    fe_de(OP_IMM, "addi");
    chk("addi_ex", {25'd0, strb()}, 32'd0);
    chk("addi_ex_sel", {28'd0, bus.alu_a_sel, bus.alu_b_sel, 1'b0}, {28'd0, 2'd0, 1'b1, 1'b0});
    chk("addi_ex_op", {30'd0, bus.alu_op}, 32'd2);
    cyc();
    chk("addi_wb", {25'd0, strb()}, 32'b0100110);
    chk("addi_wb_sel", {30'd0, bus.wb_sel}, 32'd0);
    chk("addi_wb_pcsrc", {30'd0, bus.pc_src}, 32'd0);
    cyc();
    chk("addi_instret", bus.instret, 32'd1);

    // BRANCH taken, then not taken
    bus.branch_taken = 1'b1;
    fe_de(OP_BRANCH, "beq_t");
    chk("beq_t_ex", {25'd0, strb()}, 32'b0100010);
    chk("beq_t_pcsrc", {30'd0, bus.pc_src}, 32'd1);
    chk("beq_t_op", {30'd0, bus.alu_op}, 32'd1);
    cyc();
    chk("beq_t_instret", bus.instret, 32'd2);
    bus.branch_taken = 1'b0;
    fe_de(OP_BRANCH, "beq_n");
    chk("beq_n_ex", {25'd0, strb()}, 32'b0100010);
    chk("beq_n_pcsrc", {30'd0, bus.pc_src}, 32'd0);
    cyc();
    chk("beq_n_instret", bus.instret, 32'd3);

    // LOAD with two wait cycles in MEM
    fe_de(OP_LOAD, "lw");
    chk("lw_ex_op", {29'd0, bus.alu_b_sel, bus.alu_op}, {29'd0, 1'b1, 2'd0});
    bus.mem_ready = 1'b0;
    cyc();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) bus.mem_ready = 1'b1;
      #0;
      chk($sformatf("lw_mem%0d", i), {24'd0, strb(), bus.mem_addr_sel}, {24'd0, 7'b0010000, 1'b1});
      cyc();
    end
    chk("lw_wb", {25'd0, strb()}, 32'b0100110);
    chk("lw_wb_sel", {30'd0, bus.wb_sel}, 32'd1);
    cyc();
    chk("lw_instret", bus.instret, 32'd4);

    // JALR
    fe_de(OP_JALR, "jalr");
    cyc();
    chk("jalr_wb", {25'd0, strb()}, 32'b0100110);
    chk("jalr_wb_sel", {30'd0, bus.wb_sel}, 32'd2);
    chk("jalr_pcsrc", {30'd0, bus.pc_src}, 32'd2);
    cyc();

    // LUI
    fe_de(OP_LUI, "lui");
    cyc();
    chk("lui_wb_sel", {30'd0, bus.wb_sel}, 32'd3);
    chk("lui_pcsrc", {30'd0, bus.pc_src}, 32'd0);
    cyc();
    chk("lui_instret", bus.instret, 32'd6);

    // STORE retires in MEM
    fe_de(OP_STORE, "sw");
    cyc();
    chk("sw_mem", {25'd0, strb()}, 32'b0101010);
    chk("sw_mem_addr", {31'd0, bus.mem_addr_sel}, 32'd1);
    chk("sw_pcsrc", {30'd0, bus.pc_src}, 32'd0);
    cyc();
    chk("sw_next_fetch", {25'd0, strb()}, 32'b1010000);
    chk("sw_instret", bus.instret, 32'd7);

    // Illegal opcode traps until reset
    fe_de(7'b1111111, "ill");
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("trap%0d", i), {25'd0, strb(), 1'b0} >> 1, 32'b0000001);
      cyc();
    end
    reset = 1'b1;
    #0;
    chk("trap_rst_cycle", {25'd0, strb()}, 32'd0);
    cyc();
    reset = 1'b0;
    #0;
    chk("trap_exit_fetch", {25'd0, strb()}, 32'b1010000);
    chk("trap_exit_instret", bus.instret, 32'd0);

    // Reset in the middle of a stalled STORE
    fe_de(OP_STORE, "swr");
    bus.mem_ready = 1'b0;
    cyc();
    chk("swr_mem_wait", {25'd0, strb()}, 32'b0001000);
    reset = 1'b1;
    #0;
    chk("swr_rst_strb", {25'd0, strb()}, 32'd0);
    cyc();
    reset = 1'b0;
    bus.mem_ready = 1'b1;
    #0;
    chk("swr_fetch", {25'd0, strb()}, 32'b1010000);
    chk("swr_instret", bus.instret, 32'd0);

    // instret wrap
    force dut.r_instret = 32'hFFFF_FFFF;
    #1;
    release dut.r_instret;
    chk("wrap_pre", bus.instret, 32'hFFFF_FFFF);
    fe_de(OP_BRANCH, "wrap");
    cyc();
    chk("wrap_post", bus.instret, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1);
  end

endmodule
